apb_wrr_transfer_scheduler: RTL and testbench
=============================================

Name: apb_wrr_transfer_scheduler

Overview:
- Bus-side scheduler for the shared APB channel: sequences IDLE/SETUP/ACCESS phases and grants the channel to one of MASTER_COUNT requesters.
- Arbitration is weighted round-robin with per-master burst credits.
- A watchdog terminates ACCESS phases that stall, so a hung slave cannot lock the fabric.
- Sits between the master request lines and the interconnect mux; its grant and penable drive the mux select and the outgoing enable.

Parameters:
- MASTER_COUNT, 3, number of requesting masters.
- WEIGHT_WIDTH, 2, width of each per-master weight field.
- TIMEOUT, 16, maximum ACCESS cycles before forced termination; legal range 2..255.
- TO_WIDTH, $clog2(TIMEOUT), watchdog counter width (localparam).

Ports:
- i_pclk  input  1  system clock.
- i_prstn  input  1  asynchronous, active-high reset.
- i_req  input  MASTER_COUNT  per-master transfer request, held high by the master until its o_done.
- i_weights  input  MASTER_COUNT*WEIGHT_WIDTH  field m = weight of master m. Master m may complete weight+1 consecutive transfers before losing priority. Sampled at arbitration only.
- i_pready  input  1  ready from the currently selected slave.
- i_pslverr  input  1  error from the currently selected slave.
- o_gnt  output  MASTER_COUNT  one-hot grant, registered; zero in IDLE.
- o_penable  output  1  APB enable, registered.
- o_busy  output  1  high in SETUP or ACCESS.
- o_done  output  1  one-cycle pulse on transfer completion.
- o_pslverr  output  1  error status, valid only with o_done.
- o_timeout  output  1  one-cycle pulse with o_done when the watchdog fired.

Behaviour:
- Reset (async, i_prstn=1), taking effect immediately, including mid-transfer:
  - state=IDLE; o_gnt=0, o_penable=0, o_busy=0, o_done=0, o_pslverr=0, o_timeout=0.
  - Round-robin pointer=0, credit=0, watchdog=0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If |i_req, arbitrate (see below); next cycle state=SETUP, o_gnt=winner, o_busy=1, o_penable=0.
  - Otherwise remain in IDLE.
- SETUP: always exactly one cycle. Next state=ACCESS, o_penable=1, watchdog=0.
- ACCESS, each cycle:
  - If i_pready=1: complete. Next cycle o_done=1, o_pslverr=i_pslverr, o_timeout=0.
  - Else if watchdog==TIMEOUT-1: complete. Next cycle o_done=1, o_pslverr=1, o_timeout=1.
  - Else watchdog+=1.
  - i_pready arriving on the limit cycle is a normal completion, not a timeout.
  - Maximum ACCESS length is TIMEOUT cycles.
- On completion:
  - o_penable drops to 0.
  - Arbitration runs on the same cycle's i_req with the granted master's request masked off, because that master's request is being retired.
  - If any request remains, next state=SETUP with the new o_gnt (back-to-back, no IDLE cycle). Otherwise next state=IDLE, o_gnt=0, o_busy=0.
- Arbitration (combinational on i_req, result registered):
  - If the last granted master L still requests and credit>0, grant L again and decrement credit.
  - Otherwise search from pointer upward with wrap-around; the first requesting master W wins. Set credit=weight[W], pointer=(W+1) mod MASTER_COUNT.
  - On the back-to-back path, the masked-off L is treated as requesting for the credit check only if L re-raises i_req in the completion cycle. Masters drop i_req for at least one cycle after o_done; L is therefore normally excluded.
- A master dropping i_req while granted has no effect; the transfer runs to completion or timeout.
- Simultaneous requests are resolved purely by pointer order.
- Requests arriving during SETUP/ACCESS wait; there is no preemption.
- o_gnt is always one-hot or zero; never multi-hot.

Test Plan:
- Single request: i_req=3'b010 in IDLE, i_pready high on 3rd ACCESS cycle.
  → o_gnt=010 for SETUP plus 3 ACCESS cycles; o_penable high 3 cycles; o_done pulse with o_pslverr=0; return to IDLE with o_gnt=0.
- Round-robin: all weights=0, i_req=3'b111 held (each master re-raises after one low cycle), pready on first ACCESS cycle.
  → grant order 001,010,100,001; each o_done followed directly by SETUP (no IDLE cycle).
- Weighted: weights m0=2, m1=0, m2=0; all masters continuously requesting.
  → grant sequence m0,m0,m0,m1,m2,m0,m0,m0.
- Timeout: TIMEOUT=16, i_req=3'b001, i_pready held low.
  → o_penable high exactly 16 cycles; then o_done=1, o_pslverr=1, o_timeout=1; next cycle all outputs 0.
- Boundary: i_pready=1 with i_pslverr=1 on the 16th ACCESS cycle.
  → o_done=1, o_pslverr=1, o_timeout=0.
- Reset mid-ACCESS: assert i_prstn during ACCESS with o_gnt=100.
  → o_gnt=0 and o_penable=0 immediately (asynchronous); after release, i_req=3'b111 grants master 0 first.

Source files
------------

// File: rtl/apb_wrr_transfer_scheduler.sv
// APB channel scheduler: IDLE/SETUP/ACCESS phase sequencing, weighted round-robin
// grant with per-master burst credits, and an ACCESS-phase watchdog.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transfer; o_gnt=0, arbitrates when any request is present
// ST_SETUP  | APB setup phase, one cycle, o_gnt valid, o_penable low
// ST_ACCESS | APB access phase, o_penable high, waits for i_pready or watchdog
module apb_wrr_transfer_scheduler #(
   parameter int MASTER_COUNT = 3,
   parameter int WEIGHT_WIDTH = 2,
   parameter int TIMEOUT      = 16
) (
   input  logic                                 i_pclk,
   input  logic                                 i_prstn,
   input  logic [MASTER_COUNT-1:0]              i_req,
   input  logic [MASTER_COUNT*WEIGHT_WIDTH-1:0] i_weights,
   input  logic                                 i_pready,
   input  logic                                 i_pslverr,
   output logic [MASTER_COUNT-1:0]              o_gnt,
   output logic                                 o_penable,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_pslverr,
   output logic                                 o_timeout
);

   localparam int TO_WIDTH = $clog2(TIMEOUT);
   localparam int IDX_W    = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [TO_WIDTH-1:0] WD_LIMIT = TO_WIDTH'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]    IDX_MAX  = IDX_W'(MASTER_COUNT - 1);

   logic [1:0]              state_q;
   logic [MASTER_COUNT-1:0] gnt_q;
   logic                    penable_q;
   logic                    done_q;
   logic                    pslverr_q;
   logic                    timeout_q;
   logic [TO_WIDTH-1:0]     wd_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        last_q;
   logic [WEIGHT_WIDTH-1:0] credit_q;

   logic [MASTER_COUNT-1:0] arb_req;
   logic [MASTER_COUNT-1:0] win_onehot;
   logic [IDX_W-1:0]        search_idx;
   logic [IDX_W-1:0]        sel_idx;
   logic [IDX_W-1:0]        ptr_next;
   logic [WEIGHT_WIDTH-1:0] search_weight;
   logic                    keep_last;
   logic                    search_found;
   logic                    any_win;
   logic                    complete;
   logic                    arb_take;
   int                      cand;

   assign complete = (state_q == ST_ACCESS) && (i_pready || (wd_q == WD_LIMIT));
   assign arb_take = any_win && ((state_q == ST_IDLE) || complete);

   // On completion the retiring master is masked from the pointer search; it can
   // only win again through the credit path, and only if its request is still up.
   always_comb begin
      arb_req = i_req;
      if (state_q == ST_ACCESS) begin
         arb_req = i_req & ~gnt_q;
      end
      keep_last    = i_req[last_q] && (credit_q != '0);
      search_found = 1'b0;
      search_idx   = '0;
      cand         = 0;
      for (int i = 0; i < MASTER_COUNT; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= MASTER_COUNT) begin
            cand = cand - MASTER_COUNT;
         end
         if (!search_found && arb_req[cand]) begin
            search_found = 1'b1;
            search_idx   = IDX_W'(cand);
         end
      end
      sel_idx = keep_last ? last_q : search_idx;
      any_win = keep_last || search_found;
      win_onehot = '0;
      win_onehot[sel_idx] = any_win;
      ptr_next = (search_idx == IDX_MAX) ? '0 : search_idx + 1'b1;
      search_weight = i_weights[int'(search_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   end

   always_ff @(posedge i_pclk or posedge i_prstn) begin
      if (i_prstn) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         penable_q <= 1'b0;
         done_q    <= 1'b0;
         pslverr_q <= 1'b0;
         timeout_q <= 1'b0;
         wd_q      <= '0;
         ptr_q     <= '0;
         last_q    <= '0;
         credit_q  <= '0;
      end else begin
         done_q    <= 1'b0;
         pslverr_q <= 1'b0;
         timeout_q <= 1'b0;

         if (arb_take) begin
            if (keep_last) begin
               credit_q <= credit_q - 1'b1;
            end else begin
               credit_q <= search_weight;
               ptr_q    <= ptr_next;
               last_q   <= search_idx;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (any_win) begin
                  state_q <= ST_SETUP;
                  gnt_q   <= win_onehot;
               end
            end
            ST_SETUP: begin
               state_q   <= ST_ACCESS;
               penable_q <= 1'b1;
               wd_q      <= '0;
            end
            ST_ACCESS: begin
               if (complete) begin
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  pslverr_q <= i_pready ? i_pslverr : 1'b1;
                  timeout_q <= ~i_pready;
                  gnt_q     <= win_onehot;
                  state_q   <= any_win ? ST_SETUP : ST_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               gnt_q     <= '0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_gnt     = gnt_q;
   assign o_penable = penable_q;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;
   assign o_pslverr = pslverr_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_apb_wrr_transfer_scheduler.sv
// Directed bench for apb_wrr_transfer_scheduler: vector table for single transfers,
// hand sequences for round-robin, weighted credits, watchdog and async reset.
module tb_apb_wrr_transfer_scheduler;

   logic       i_pclk;
   logic       i_prstn;
   logic [2:0] i_req;
   logic [5:0] i_weights;
   logic       i_pready;
   logic       i_pslverr;
   logic [2:0] o_gnt;
   logic       o_penable;
   logic       o_busy;
   logic       o_done;
   logic       o_pslverr;
   logic       o_timeout;

   int checks = 0;
   int errors = 0;

   apb_wrr_transfer_scheduler #(
      .MASTER_COUNT(3),
      .WEIGHT_WIDTH(2),
      .TIMEOUT(16)
   ) dut (
      .i_pclk   (i_pclk),
      .i_prstn  (i_prstn),
      .i_req    (i_req),
      .i_weights(i_weights),
      .i_pready (i_pready),
      .i_pslverr(i_pslverr),
      .o_gnt    (o_gnt),
      .o_penable(o_penable),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_pslverr(o_pslverr),
      .o_timeout(o_timeout)
   );

   initial i_pclk = 1'b0;
   always #5 i_pclk = ~i_pclk;

   // {gnt[2:0], penable, busy, done, pslverr, timeout}
   typedef struct {
      logic [2:0] req;
      logic       pready;
      logic       pslverr;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [7:0] outs();
      return {o_gnt, o_penable, o_busy, o_done, o_pslverr, o_timeout};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_pclk);
      #1;
   endtask

   task automatic reset_dut();
      i_prstn   = 1'b1;
      i_req     = '0;
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      repeat (2) @(posedge i_pclk);
      #1;
      i_prstn = 1'b0;
   endtask

   logic [2:0] got_g[8];
   logic [2:0] exp_rr[4];
   logic [2:0] exp_w[8];
   logic [2:0] cur;
   logic [7:0] snap;
   int n;
   int cnt;
   logic got;

   initial begin
      tbl[0] = '{3'b010, 1'b0, 1'b0, 8'b010_0_1_0_0_0};
      tbl[1] = '{3'b010, 1'b0, 1'b0, 8'b010_1_1_0_0_0};
      tbl[2] = '{3'b010, 1'b0, 1'b0, 8'b010_1_1_0_0_0};
      tbl[3] = '{3'b010, 1'b0, 1'b0, 8'b010_1_1_0_0_0};
      tbl[4] = '{3'b010, 1'b1, 1'b0, 8'b000_0_0_1_0_0};
      tbl[5] = '{3'b000, 1'b0, 1'b0, 8'b000_0_0_0_0_0};
      tbl[6] = '{3'b100, 1'b0, 1'b0, 8'b100_0_1_0_0_0};
      tbl[7] = '{3'b100, 1'b0, 1'b1, 8'b100_1_1_0_0_0};
      tbl[8] = '{3'b100, 1'b1, 1'b1, 8'b000_0_0_1_1_0};
      tbl[9] = '{3'b000, 1'b0, 1'b0, 8'b000_0_0_0_0_0};
      exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_w  = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001, 3'b001};

      i_weights = '0;
      reset_dut();
      check("reset_outs", 32'(outs()), 32'h0);

      for (int v = 0; v < 10; v++) begin
         i_req     = tbl[v].req;
         i_pready  = tbl[v].pready;
         i_pslverr = tbl[v].pslverr;
         step();
         check($sformatf("vec%0d", v), 32'(outs()), 32'(tbl[v].exp));
      end

      // Round-robin, weights 0; retiring master drops its request for one cycle.
      reset_dut();
      i_weights = 6'b00_00_00;
      i_req = 3'b111;
      i_pready = 1'b1;
      n = 0;
      cur = '0;
      for (int k = 0; k < 8; k++) got_g[k] = '0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         step();
         i_req = 3'b111;
         if (o_done) begin
            check("rr_b2b", 32'(o_busy), 32'h1);
            i_req = 3'b111 & ~cur;
         end
         if (o_busy && !o_penable) begin
            got_g[n] = o_gnt;
            cur = o_gnt;
            n++;
         end
      end
      for (int k = 0; k < 4; k++) check($sformatf("rr_gnt%0d", k), 32'(got_g[k]), 32'(exp_rr[k]));

      // Weighted: m0 weight 2, all continuously requesting.
      reset_dut();
      i_weights = 6'b00_00_10;
      i_req = 3'b111;
      i_pready = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) got_g[k] = '0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         step();
         if (o_done) check("w_b2b", 32'(o_busy), 32'h1);
         if (o_busy && !o_penable) begin
            got_g[n] = o_gnt;
            n++;
         end
      end
      for (int k = 0; k < 8; k++) check($sformatf("w_gnt%0d", k), 32'(got_g[k]), 32'(exp_w[k]));

      // Watchdog: slave never ready.
      reset_dut();
      i_weights = '0;
      i_req = 3'b001;
      cnt = 0;
      got = 1'b0;
      snap = '0;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (o_penable) cnt++;
         if (o_done) begin
            got = 1'b1;
            snap = outs();
            i_req = '0;
         end
      end
      check("to_len", 32'(cnt), 32'd16);
      check("to_seen", 32'(got), 32'h1);
      check("to_done", 32'(snap), 32'(8'b000_0_0_1_1_1));
      i_req = '0;
      step();
      check("to_after", 32'(outs()), 32'h0);

      // Ready with error on the last allowed ACCESS cycle is a normal completion.
      i_req = 3'b001;
      cnt = 0;
      for (int c = 0; c < 40 && cnt < 16; c++) begin
         step();
         if (o_penable) cnt++;
      end
      check("bnd_len", 32'(cnt), 32'd16);
      i_pready  = 1'b1;
      i_pslverr = 1'b1;
      step();
      check("bnd_done", 32'(outs()), 32'(8'b000_0_0_1_1_0));
      i_req = '0;
      i_pready = 1'b0;
      i_pslverr = 1'b0;
      step();
      check("bnd_after", 32'(outs()), 32'h0);

      // Async reset mid-ACCESS; m2 holds credit so a lost reset would re-grant m2.
      reset_dut();
      i_weights = 6'b01_00_00;
      i_req = 3'b100;
      step();
      step();
      check("rst_pre", 32'({o_gnt, o_penable}), 32'(4'b100_1));
      #2;
      i_prstn = 1'b1;
      #1;
      check("rst_async", 32'({o_gnt, o_penable, o_busy}), 32'h0);
      @(posedge i_pclk);
      #1;
      i_prstn = 1'b0;
      i_req = 3'b111;
      step();
      check("rst_first_gnt", 32'(o_gnt), 32'(3'b001));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
